// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with SRAM-style handshake and IF/ID output registers
module if_fetch #(
  parameter int          ADEL_BIT    = 1,
  parameter logic [31:0] BUBBLE_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] i_pc,
  input  logic [6:0]  i_except,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        stallreq_if,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic [6:0]  o_except
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, CANCEL} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_inst, r_addr;
  logic [6:0]  r_exc;
  logic        w_cand, w_adel, w_unused;
  assign w_cand   = (i_pc != '0) && !flush;
  assign w_adel   = i_except[ADEL_BIT];
  assign inst_req = (r_state == REQ);
  assign inst_addr = r_addr;
  assign w_unused = ^{stall[5:3], stall[0]};
  // next-state and stall request; DONE is the only busy-free state besides an empty IDLE
  always_comb begin
    w_next      = r_state;
    stallreq_if = 1'b0;
    case (r_state)
      IDLE: begin
        stallreq_if = w_cand;
        w_next      = !w_cand ? IDLE : w_adel ? DONE : REQ;
      end
      REQ: begin
        stallreq_if = 1'b1;
        w_next      = inst_addr_ok ? (flush ? CANCEL : WAIT) : (flush ? IDLE : REQ);
      end
      WAIT: begin
        stallreq_if = 1'b1;
        w_next      = flush ? (inst_data_ok ? IDLE : CANCEL) : (inst_data_ok ? DONE : WAIT);
      end
      DONE:   w_next = (flush || !stall[1]) ? IDLE : DONE;
      CANCEL: begin
        stallreq_if = 1'b1;
        w_next      = inst_data_ok ? IDLE : CANCEL;
      end
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // latch the fetched pc/exception, request address and returned instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= '0;
      r_exc  <= '0;
      r_inst <= BUBBLE_INST;
      r_addr <= '0;
    end else begin
      if (r_state == IDLE && w_cand) begin
        r_pc  <= i_pc;
        r_exc <= i_except;
        if (w_adel) r_inst <= BUBBLE_INST;
        else r_addr <= i_pc;
      end
      if (r_state == WAIT && inst_data_ok && !flush) r_inst <= inst_rdata;
    end
  end
  // IF/ID registers: flush and decode-running-while-fetch-stalled both insert bubbles
  always_ff @(posedge clk) begin
    if (reset || flush || (stall[1] && !stall[2]) || (!stall[1] && r_state != DONE)) begin
      o_pc     <= '0;
      o_inst   <= BUBBLE_INST;
      o_except <= '0;
    end else if (!stall[1]) begin
      o_pc     <= r_pc;
      o_inst   <= r_inst;
      o_except <= r_exc;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        reset, flush, inst_req, inst_addr_ok, inst_data_ok, stallreq_if;
  logic [5:0]  stall;
  logic [31:0] i_pc, inst_addr, inst_rdata, o_pc, o_inst;
  logic [6:0]  i_except, o_except;
  int          n_chk = 0;
  int          n_bad = 0;

  if_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .i_pc(i_pc), .i_except(i_except),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .stallreq_if(stallreq_if),
    .o_pc(o_pc), .o_inst(o_inst), .o_except(o_except)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // single-beat fetch: addr_ok in first REQ cycle, data_ok next cycle, no stalls
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input logic [6:0] exc);
    i_pc = pc; i_except = exc; settle();
    check("c0_stallreq", 32'(stallreq_if), 1);
    check("c0_req", 32'(inst_req), 0);
    tick();
    i_pc = 0; i_except = 0; inst_addr_ok = 1; settle();
    check("c1_req", 32'(inst_req), 1);
    check("c1_addr", inst_addr, pc);
    check("c1_stallreq", 32'(stallreq_if), 1);
    tick();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = data; settle();
    check("c2_req", 32'(inst_req), 0);
    check("c2_stallreq", 32'(stallreq_if), 1);
    tick();
    inst_data_ok = 0; inst_rdata = 0; settle();
    check("c3_stallreq", 32'(stallreq_if), 0);
    check("c3_opc_bubble", o_pc, 0);
    tick();
    check("ld_pc", o_pc, pc);
    check("ld_inst", o_inst, data);
    check("ld_exc", 32'(o_except), 32'(exc));
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; i_pc = 0; i_except = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    tick(); tick();
    reset = 0; settle();
    check("rst_opc", o_pc, 0);
    check("rst_oinst", o_inst, 0);
    check("rst_oexc", 32'(o_except), 0);
    check("rst_req", 32'(inst_req), 0);
    check("rst_addr", inst_addr, 0);
    check("rst_stallreq", 32'(stallreq_if), 0);

    // basic fetch, then bubble follows on the next edge
    do_fetch(32'hBFC00000, 32'h3C1D8000, 7'd0);
    tick();
    check("after_bubble_pc", o_pc, 0);
    check("after_bubble_inst", o_inst, 0);

    // slow slave
    i_pc = 32'hBFC00010; tick();
    i_pc = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("slow_req", 32'(inst_req), 1);
      check("slow_addr", inst_addr, 32'hBFC00010);
      check("slow_stallreq", 32'(stallreq_if), 1);
      check("slow_opc", o_pc, 0);
      tick();
    end
    inst_addr_ok = 1; settle();
    check("slow_req_ack", 32'(inst_req), 1);
    tick();
    inst_addr_ok = 0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("slow_wait_req", 32'(inst_req), 0);
      check("slow_wait_stallreq", 32'(stallreq_if), 1);
      tick();
    end
    inst_data_ok = 1; inst_rdata = 32'h24080001; tick();
    inst_data_ok = 0; settle();
    check("slow_done_stallreq", 32'(stallreq_if), 0);
    tick();
    check("slow_pc", o_pc, 32'hBFC00010);
    check("slow_inst", o_inst, 32'h24080001);

    // AdEL: no memory access
    i_pc = 32'hBFC00002; i_except = 7'b0000010; settle();
    check("adel_stallreq", 32'(stallreq_if), 1);
    check("adel_req0", 32'(inst_req), 0);
    tick();
    i_pc = 0; i_except = 0; settle();
    check("adel_req1", 32'(inst_req), 0);
    check("adel_done_stallreq", 32'(stallreq_if), 0);
    tick();
    check("adel_pc", o_pc, 32'hBFC00002);
    check("adel_inst", o_inst, 0);
    check("adel_exc", 32'(o_except), 32'b0000010);

    // flush in WAIT -> CANCEL, response discarded
    i_pc = 32'hBFC00020; tick();
    i_pc = 0; inst_addr_ok = 1; tick();
    inst_addr_ok = 0; flush = 1; tick();
    flush = 0; settle();
    check("cancel_stallreq", 32'(stallreq_if), 1);
    check("cancel_req", 32'(inst_req), 0);
    inst_data_ok = 1; inst_rdata = 32'hDEADBEEF; tick();
    inst_data_ok = 0; settle();
    check("cancel_inst", o_inst, 0);
    check("cancel_idle_stallreq", 32'(stallreq_if), 0);
    tick();
    check("cancel_inst2", o_inst, 0);
    do_fetch(32'hBFC00380, 32'h8C020004, 7'd0);

    // flush coincident with addr_ok -> CANCEL
    i_pc = 32'hBFC00030; tick();
    i_pc = 0; inst_addr_ok = 1; flush = 1; tick();
    inst_addr_ok = 0; flush = 0; settle();
    check("fa_cancel_stallreq", 32'(stallreq_if), 1);
    check("fa_cancel_req", 32'(inst_req), 0);
    inst_data_ok = 1; inst_rdata = 32'hCAFEF00D; tick();
    inst_data_ok = 0; settle();
    check("fa_idle_stallreq", 32'(stallreq_if), 0);
    check("fa_inst", o_inst, 0);

    // flush in REQ without addr_ok -> IDLE, request withdrawn
    i_pc = 32'hBFC00040; tick();
    i_pc = 0; flush = 1; settle();
    check("fr_req", 32'(inst_req), 1);
    tick();
    flush = 0; settle();
    check("fr_req_low", 32'(inst_req), 0);
    check("fr_stallreq", 32'(stallreq_if), 0);
    inst_data_ok = 1; inst_rdata = 32'h11111111; tick();
    inst_data_ok = 0; settle();
    check("idle_dok_stallreq", 32'(stallreq_if), 0);
    check("idle_dok_inst", o_inst, 0);
    do_fetch(32'hBFC00050, 32'h22222222, 7'd0);

    // downstream stall: outputs hold through fetch and DONE, then load once
    stall = 6'b001111;
    i_pc = 32'hBFC00060; i_except = 7'b0100000; tick();
    i_pc = 0; i_except = 0; inst_addr_ok = 1; tick();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h33333333; tick();
    inst_data_ok = 0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("stl_hold_pc", o_pc, 32'hBFC00050);
      check("stl_hold_inst", o_inst, 32'h22222222);
      check("stl_stallreq", 32'(stallreq_if), 0);
      tick();
    end
    settle();
    check("stl_still_done_pc", o_pc, 32'hBFC00050);
    stall = 0; tick();
    check("stl_load_pc", o_pc, 32'hBFC00060);
    check("stl_load_inst", o_inst, 32'h33333333);
    check("stl_load_exc", 32'(o_except), 32'b0100000);
    tick();
    check("stl_once_pc", o_pc, 0);

    // fetch stalled but decode running -> bubble
    do_fetch(32'hBFC00070, 32'h44444444, 7'd0);
    stall = 6'b000011; tick();
    check("bub_pc", o_pc, 0);
    check("bub_inst", o_inst, 0);
    stall = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
